// File: rtl/cmp_pkg.sv
// Shared definitions for serial comparator stages: FSM state type and the
// one-hot {eq,gt,lt} flag encodings produced by the 1-bit comparator.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } cmp_state_e;

  localparam logic [2:0] EQ = 3'b100;
  localparam logic [2:0] GT = 3'b010;
  localparam logic [2:0] LT = 3'b001;

endpackage

// File: rtl/cmp_beat_counter.sv
// Beat counter for serial stages: counts 0..WIDTH-1 and wraps to 0 after the
// last beat, so it never exceeds WIDTH-1.
module cmp_beat_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(WIDTH - 1);

  assign last = (count == LAST_VAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= last ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/serial_mag_compare_acc.sv
// Serial MSB-first magnitude accumulator fed by a 1-bit comparator's flags;
// yields a registered eq/gt/lt verdict, first differing bit and a one-hot error.
module serial_mag_compare_acc
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             bit_valid,
  output logic             bit_ready,
  input  logic             bit_eq,
  input  logic             bit_gt,
  input  logic             bit_lt,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_eq,
  output logic             res_gt,
  output logic             res_lt,
  output logic [CNT_W-1:0] diff_pos,
  output logic             err
);

  cmp_state_e       state, state_next;
  logic             decided, gt_q, lt_q, err_q;
  logic [CNT_W-1:0] pos_q;
  logic [CNT_W-1:0] count;
  logic             last;
  logic [2:0]       flags;
  logic             one_hot;
  logic             accept;
  logic             begin_run;

  assign flags     = {bit_eq, bit_gt, bit_lt};
  assign one_hot   = (flags == EQ) || (flags == GT) || (flags == LT);
  assign accept    = (state == SHIFT) && bit_valid && !abort;
  assign begin_run = (state == IDLE) && start && !abort;

  cmp_beat_counter #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_counter (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (abort || begin_run),
    .en   (accept),
    .count(count),
    .last (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    bit_ready  = 1'b0;
    busy       = 1'b0;
    res_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = SHIFT;
      end
      SHIFT: begin
        bit_ready = 1'b1;
        busy      = 1'b1;
        if (bit_valid && last) state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  // Verdict registers stay untouched outside SHIFT, so they hold through DONE
  // and after hand-off until the next start clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      decided <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      pos_q   <= '0;
      err_q   <= 1'b0;
    end else if (abort || begin_run) begin
      decided <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      pos_q   <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      if (!one_hot) begin
        err_q <= 1'b1;
      end else if (!decided && (flags != EQ)) begin
        decided <= 1'b1;
        gt_q    <= (flags == GT);
        lt_q    <= (flags == LT);
        pos_q   <= CNT_W'(WIDTH - 1) - count;
      end
    end
  end

  assign res_eq   = !decided;
  assign res_gt   = gt_q;
  assign res_lt   = lt_q;
  assign diff_pos = pos_q;
  assign err      = err_q;

endmodule

// File: doc/serial_mag_compare_acc.md
Name: serial_mag_compare_acc

Overview:
- Sequential downstream stage for the 1-bit equality/greater/less comparator.
- Consumes that comparator's per-bit flags one bit per accepted beat, MSB first, over WIDTH beats.
- Produces a registered WIDTH-bit magnitude verdict (eq/gt/lt), the position of the first differing bit, and an error flag if the incoming flags were not one-hot.
- Uses a valid/ready handshake on input and output, so WIDTH=1 reduces to a registered copy of the 1-bit comparator.

Parameters:
- WIDTH, 8: number of bit-beats per comparison (operand width); legal range 1..64.
- CNT_W, $clog2(WIDTH) with minimum 1: width of the beat counter and diff_pos.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begins a comparison; honoured only in IDLE.
- abort  in  1  synchronous cancel from any state.
- bit_valid  in  1  bit-flag beat present.
- bit_ready  out  1  stage accepts a beat.
- bit_eq  in  1  equality flag from the 1-bit comparator.
- bit_gt  in  1  greater-than flag from the 1-bit comparator.
- bit_lt  in  1  less-than flag from the 1-bit comparator.
- busy  out  1  high in SHIFT or DONE.
- res_valid  out  1  verdict available.
- res_ready  in  1  consumer accepts the verdict.
- res_eq  out  1  verdict: a == b.
- res_gt  out  1  verdict: a > b.
- res_lt  out  1  verdict: a < b.
- diff_pos  out  CNT_W  bit index (WIDTH-1 = MSB) of the first differing bit; 0 when res_eq.
- err  out  1  at least one beat had non-one-hot flags.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, count=0, decided=0.
  - Outputs at reset: bit_ready=0, busy=0, res_valid=0, res_eq=1, res_gt=0, res_lt=0, diff_pos=0, err=0.
- States: IDLE, SHIFT, DONE. Priority each cycle: abort > state logic.
- IDLE:
  - start=1 -> SHIFT next cycle.
  - On that transition clear count, decided, gt/lt, diff_pos and err.
  - bit_ready=0.
- SHIFT:
  - bit_ready=1; a beat is accepted when bit_valid && bit_ready.
  - Per accepted beat, count increments.
  - If decided=0 and bit_gt=1: decided=1, gt=1, diff_pos=WIDTH-1-count.
  - If decided=0 and bit_lt=1: decided=1, lt=1, diff_pos=WIDTH-1-count.
  - Once decided, later beats do not change gt/lt/diff_pos (sticky MSB-first rule), but are still consumed and counted.
  - One-hot check per beat: if {bit_eq,bit_gt,bit_lt} is not exactly one-hot, set err=1 (sticky).
  - A non-one-hot beat does not decide the verdict, and its gt/lt flags are ignored for that beat.
  - Beat accepted with count==WIDTH-1 -> DONE next cycle.
  - No bubbles required: WIDTH back-to-back beats give DONE after exactly WIDTH+1 cycles from start.
  - bit_valid=0 stalls the stage without losing state.
- DONE:
  - res_valid=1.
  - res_eq = !decided; res_gt = gt; res_lt = lt. Exactly one of the three is high.
  - Verdict, diff_pos and err are held stable while res_valid && !res_ready.
  - res_ready=1 -> IDLE next cycle; res_* outputs retain their values until the next start.
  - bit_ready=0; start is ignored.
- abort=1 in any state:
  - Next state IDLE, count=0, res_valid=0.
  - res_eq=1, res_gt=0, res_lt=0, diff_pos=0, err=0.
  - An in-flight beat in the same cycle is discarded.
- start=1 in SHIFT/DONE: ignored, no effect.
- Counter: never exceeds WIDTH-1. WIDTH=1 gives a single beat, then DONE.
- Mid-operation reset: asynchronously returns to the reset values above. No partial verdict is ever presented.

Decomposition:
- Shared package cmp_pkg:
  - state enum typedef cmp_state_e {IDLE, SHIFT, DONE}.
  - Localparams for one-hot flag encodings EQ=3'b100, GT=3'b010, LT=3'b001, packed as {eq,gt,lt}.
- Single module plus one natural sub-module: cmp_beat_counter.
  - Holds the CNT_W up-counter with clear, enable and a last flag.
  - Reusable by other serial stages.
- The 1-bit comparator stays a separate instance upstream; it is not embedded.

Test Plan:
- WIDTH=4, a=4'b1010, b=4'b1010 streamed MSB-first, all eq beats -> res_valid at cycle 5 after start; res_eq=1, res_gt=0, res_lt=0, diff_pos=0, err=0.
- WIDTH=4, a=4'b1011, b=4'b1001 -> beat 2 gives gt -> res_gt=1, diff_pos=1. A trailing lt beat at beat 3 (a=4'b1010, b=4'b1001 variant) does not flip the verdict.
- WIDTH=4, a=4'b0111, b=4'b1000 with bit_valid toggling 1,0,1,0 -> stalls honoured; res_lt=1, diff_pos=3; DONE only after 4 accepted beats.
- Beat with flags 3'b110 inside an otherwise equal stream -> err=1, res_eq=1. Hold res_ready=0 for 3 cycles -> outputs stable; res_ready=1 -> IDLE.
- abort asserted after 2 beats, then start with a fresh equal stream -> no res_valid from the first run; the second run is clean (err=0, res_eq=1). start pulsed during SHIFT is ignored.
- rst_n dropped asynchronously mid-SHIFT (between clock edges) -> all outputs at reset values immediately; after release, IDLE with bit_ready=0.
